// File: rtl/wb_mem_slave.sv
// Wishbone B4 classic-cycle memory responder backed by a word-addressed RAM.
// Each request is latched in IDLE, held for WAIT_STATES cycles in WAIT, then
// answered for exactly one cycle in RESP with either ack (in-window, aligned)
// or err. Writes honour byte lanes; reads return the full word on ack only.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   wb_cyc_i, wb_stb_i  bus cycle and strobe
//   wb_we_i             1 = write
//   wb_adr_i            byte address
//   wb_dat_i, wb_sel_i  write data and byte lane enables
//   wb_ack_o, wb_err_o  one-cycle acknowledge / bus error
//   wb_dat_o            read data, zero outside read-ack cycles
//   rd_count_o          acked reads
//   wr_count_o          acked writes
//   err_count_o         error responses
module wb_mem_slave #(
  parameter int unsigned             XLEN        = 32,
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             MEM_WORDS   = 16384,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
  parameter int unsigned             WAIT_STATES = 0,
  parameter string                   INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [XLEN-1:0]       wb_dat_i,
  input  logic [XLEN/8-1:0]     wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [XLEN-1:0]       wb_dat_o,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o,
  output logic [31:0]           err_count_o
);

  localparam int unsigned           NumLanes  = XLEN / 8;
  localparam int unsigned           IdxW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0]   MemWordsW = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [3:0]            WaitInit  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    commit;

  logic [ADDR_WIDTH-1:0]   adr_q;
  logic                    we_q;
  logic [XLEN-1:0]         dat_q;
  logic [NumLanes-1:0]     sel_q;
  logic                    bad_q;
  logic [XLEN-1:0]         rd_data_q;
  logic [31:0]             rd_cnt_q, wr_cnt_q, err_cnt_q;

  logic [XLEN-1:0]         mem_q [MEM_WORDS];

  logic                    req;
  logic                    in_idle;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic                    cur_we;
  logic [XLEN-1:0]         cur_dat;
  logic [NumLanes-1:0]     cur_sel;
  logic [ADDR_WIDTH-1:0]   cur_off;
  logic [ADDR_WIDTH-1:0]   cur_word;
  logic                    cur_bad;
  logic [IdxW-1:0]         cur_idx;

  assign req     = wb_cyc_i & wb_stb_i;
  assign in_idle = (state_q == StIdle);

  // With zero wait states the RAM is committed on the same edge that latches
  // the request, so the live bus values are used while in IDLE.
  assign cur_adr  = in_idle ? wb_adr_i : adr_q;
  assign cur_we   = in_idle ? wb_we_i  : we_q;
  assign cur_dat  = in_idle ? wb_dat_i : dat_q;
  assign cur_sel  = in_idle ? wb_sel_i : sel_q;

  assign cur_off  = cur_adr - BASE_ADDR;
  assign cur_word = cur_off >> 2;
  assign cur_idx  = cur_word[IdxW-1:0];
  assign cur_bad  = in_idle ? ((cur_adr[1:0] != 2'b00) | (cur_adr < BASE_ADDR) |
                               ({1'b0, cur_word} >= MemWordsW))
                            : bad_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = WaitInit;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      sel_q     <= '0;
      bad_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel_i;
        bad_q <= cur_bad;
      end
      if (state_q == StResp) begin
        if (bad_q) begin
          err_cnt_q <= err_cnt_q + 32'd1;
        end else if (we_q) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end
      end
    end
  end

  // RAM port: no reset on contents; reset only blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && !cur_bad) begin
      if (cur_we) begin
        for (int i = 0; i < NumLanes; i++) begin
          if (cur_sel[i]) begin
            mem_q[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
          end
        end
      end else begin
        rd_data_q <= mem_q[cur_idx];
      end
    end
  end

  assign wb_ack_o    = (state_q == StResp) & ~bad_q;
  assign wb_err_o    = (state_q == StResp) & bad_q;
  assign wb_dat_o    = (wb_ack_o & ~we_q) ? rd_data_q : '0;
  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc0 = 1'b0, cyc3 = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;

  logic        ack0, err0, ack3, err3;
  logic [31:0] dat0, dat3, rc0, wc0, ec0, rc3, wc3, ec3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_slave #(
    .XLEN(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000),
    .WAIT_STATES(0), .INIT_FILE("")
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack0), .wb_err_o(err0),
    .wb_dat_o(dat0), .rd_count_o(rc0), .wr_count_o(wc0), .err_count_o(ec0)
  );

  wb_mem_slave #(
    .XLEN(32), .ADDR_WIDTH(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0100),
    .WAIT_STATES(3), .INIT_FILE("")
  ) u_dut3 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_ack_o(ack3), .wb_err_o(err3),
    .wb_dat_o(dat3), .rd_count_o(rc3), .wr_count_o(wc3), .err_count_o(ec3)
  );

  // Runs one transfer on the selected instance and reports the first response.
  // lat is the number of edges after the request edge (1 = cycle after edge N);
  // lat = 0 means no response arrived within the cycle budget.
  task automatic xfer(input int which, input logic we_v, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic ga, output logic ge, output logic [31:0] gd,
                      output int lat);
    logic an, en;
    ga = 1'b0; ge = 1'b0; gd = '0; lat = 0;
    @(negedge clk);
    if (which == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
    stb = 1'b1; we = we_v; adr = a; wdat = d; sel = s;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      an = (which == 0) ? ack0 : ack3;
      en = (which == 0) ? err0 : err3;
      if (an || en) begin
        ga = an; ge = en; gd = (which == 0) ? dat0 : dat3; lat = i;
        break;
      end
    end
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", ack0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err0 got %b want 0", err0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL reset_dat0 got %h want 0", dat0); end
    checks++; if ({rc0, wc0, ec0} !== 96'h0) begin errors++; $display("FAIL reset_cnt0 got %h %h %h want 0", rc0, wc0, ec0); end
    checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL reset_ackerr3 got %b want 00", {ack3, err3}); end
    checks++; if ({rc3, wc3, ec3} !== 96'h0) begin errors++; $display("FAIL reset_cnt3 got %h %h %h want 0", rc3, wc3, ec3); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ga, ge; logic [31:0] gd; int lat;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b10) begin errors++; $display("FAIL basic_wr_resp got %b want 10", {ga, ge}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_lat got %0d want 1", lat); end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b10) begin errors++; $display("FAIL basic_rd_resp got %b want 10", {ga, ge}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_lat got %0d want 1", lat); end
    checks++; if (gd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got %h want DEADBEEF", gd); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL basic_ack_one_cycle got %b want 0", ack0); end
    checks++; if (dat0 !== 32'h0) begin errors++; $display("FAIL basic_dat_idle got %h want 0", dat0); end
    checks++; if (wc0 !== 32'd1) begin errors++; $display("FAIL basic_wr_count got %0d want 1", wc0); end
    checks++; if (rc0 !== 32'd1) begin errors++; $display("FAIL basic_rd_count got %0d want 1", rc0); end
  endtask

  task automatic test_byte_lanes();
    logic ga, ge; logic [31:0] gd; int lat;
    xfer(0, 1'b1, 32'h10, 32'h00AA0000, 4'h4, ga, ge, gd, lat);
    checks++; if (ga !== 1'b1) begin errors++; $display("FAIL lane_wr_ack got %b want 1", ga); end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h1, ga, ge, gd, lat);
    checks++; if (gd !== 32'hDEAABEEF) begin errors++; $display("FAIL lane_rd_data got %h want DEAABEEF", gd); end
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, ga, ge, gd, lat);
    checks++; if (ga !== 1'b1) begin errors++; $display("FAIL lane_sel0_ack got %b want 1", ga); end
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if (gd !== 32'hDEAABEEF) begin errors++; $display("FAIL lane_sel0_data got %h want DEAABEEF", gd); end
  endtask

  task automatic test_errors();
    logic ga, ge; logic [31:0] gd; int lat;
    xfer(0, 1'b0, 32'h12, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b01) begin errors++; $display("FAIL err_misalign_resp got %b want 01", {ga, ge}); end
    checks++; if (gd !== 32'h0) begin errors++; $display("FAIL err_misalign_dat got %h want 0", gd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_misalign_lat got %0d want 1", lat); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", err0); end
    xfer(0, 1'b1, 32'h0, 32'h11223344, 4'hF, ga, ge, gd, lat);
    xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b01) begin errors++; $display("FAIL err_oow_resp got %b want 01", {ga, ge}); end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if (gd !== 32'h11223344) begin errors++; $display("FAIL err_word0_kept got %h want 11223344", gd); end
    xfer(0, 1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b10) begin errors++; $display("FAIL last_word_wr got %b want 10", {ga, ge}); end
    xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if (gd !== 32'hA5A5A5A5) begin errors++; $display("FAIL last_word_rd got %h want A5A5A5A5", gd); end
    checks++; if (ec0 !== 32'd2) begin errors++; $display("FAIL err_count got %0d want 2", ec0); end
    checks++; if (wc0 !== 32'd5) begin errors++; $display("FAIL wr_count_after_err got %0d want 5", wc0); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    @(negedge clk);
    cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack0;
    end
    cyc0 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    checks++; if (pat !== 4'b0101) begin errors++; $display("FAIL b2b_pattern got %b want 0101", pat); end
    checks++; if (rc0 !== 32'd7) begin errors++; $display("FAIL b2b_rd_count got %0d want 7", rc0); end
  endtask

  task automatic test_wait_states();
    logic ga, ge; logic [31:0] gd; int lat;
    xfer(3, 1'b1, 32'h120, 32'hCAFEF00D, 4'hF, ga, ge, gd, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_wr_lat got %0d want 4", lat); end
    xfer(3, 1'b0, 32'h120, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b10) begin errors++; $display("FAIL ws_rd_resp got %b want 10", {ga, ge}); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_rd_lat got %0d want 4", lat); end
    checks++; if (gd !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd_data got %h want CAFEF00D", gd); end
    xfer(3, 1'b0, 32'hFC, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if ({ga, ge} !== 2'b01) begin errors++; $display("FAIL ws_below_base got %b want 01", {ga, ge}); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws_err_lat got %0d want 4", lat); end
    checks++; if ({rc3, wc3, ec3} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL ws_counts got %0d %0d %0d want 1 1 1", rc3, wc3, ec3); end
  endtask

  task automatic test_abort();
    logic ga, ge; logic [31:0] gd; int lat;
    @(negedge clk);
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h120; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk); #1;
    checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL abort_latch got %b want 00", {ack3, err3}); end
    @(posedge clk); #1;
    checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL abort_wait1 got %b want 00", {ack3, err3}); end
    cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL abort_quiet%0d got %b want 00", i, {ack3, err3}); end
    end
    xfer(3, 1'b0, 32'h120, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if (gd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_old_data got %h want CAFEF00D", gd); end
    checks++; if (wc3 !== 32'd1) begin errors++; $display("FAIL abort_wr_count got %0d want 1", wc3); end
    checks++; if (rc3 !== 32'd2) begin errors++; $display("FAIL abort_rd_count got %0d want 2", rc3); end
  endtask

  task automatic test_reset_in_wait();
    logic ga, ge; logic [31:0] gd; int lat;
    @(negedge clk);
    cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h120; wdat = 32'h55555555; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL rstwait_ackerr got %b want 00", {ack3, err3}); end
    checks++; if ({rc3, wc3, ec3} !== 96'h0) begin errors++; $display("FAIL rstwait_counts got %h %h %h want 0", rc3, wc3, ec3); end
    rst = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({ack3, err3} !== 2'b00) begin errors++; $display("FAIL rstwait_quiet%0d got %b want 00", i, {ack3, err3}); end
    end
    xfer(3, 1'b0, 32'h120, 32'h0, 4'hF, ga, ge, gd, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstwait_rd_lat got %0d want 4", lat); end
    checks++; if (gd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstwait_mem_kept got %h want CAFEF00D", gd); end
    checks++; if ({rc3, wc3} !== {32'd1, 32'd0}) begin errors++; $display("FAIL rstwait_after got %0d %0d want 1 0", rc3, wc3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_wait_states();
    test_abort();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
